// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: records retired instructions into a circular buffer with
// cycle stamps, a PC breakpoint that freezes capture and a show-ahead read port.
module exec_trace_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned WRAP  = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     commit,
    input  logic [XLEN-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic [4:0]               rd,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     arm,
    input  logic                     bp_en,
    input  logic [XLEN-1:0]          bp_addr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [CW-1:0]            rd_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halt,
    output logic [1:0]               state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 2 * XLEN + 32 + 5 + CW;
    localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StFrozen  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   stamp_q;
    logic            mem_we;
    logic            push, pop, full;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;

    assign push = commit && (state_q == StCapture);
    assign pop  = rd_valid && rd_ready;
    assign full = (count_q == CntFull);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        // Arm overrides both a concurrent commit and a concurrent pop.
        if (arm) begin
            state_d    = StCapture;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push && bp_en && (pc == bp_addr)) begin
                state_d = StFrozen;
            end
            if (push && pop) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else if (push && !full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + (AW + 1)'(1);
            end else if (push) begin
                overflow_d = 1'b1;
                if (WRAP != 0) begin
                    // Full: the tail slot is the head slot, so the oldest entry is replaced.
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end else if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stamp_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stamp_q    <= stamp_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && mem_we) begin
            mem[wr_ptr_q] <= {pc, instr, rd, wdata, stamp_q};
        end
    end

    // Fields are forced to zero when empty or in reset so stale memory never leaks out.
    assign head     = (rd_valid && RST) ? mem[rd_ptr_q] : '0;
    assign rd_valid = (count_q != '0);
    assign rd_stamp = head[CW-1:0];
    assign rd_wdata = head[CW +: XLEN];
    assign rd_rd    = head[CW + XLEN +: 5];
    assign rd_instr = head[CW + XLEN + 5 +: 32];
    assign rd_pc    = head[CW + XLEN + 37 +: XLEN];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign halt     = (state_q == StFrozen);
    assign state    = state_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench: one WRAP=1 and one WRAP=0 instance (DEPTH=4) share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_exec_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [15:0] stamp;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [4:0]  rd = '0;
    logic [31:0] wdata = '0;
    logic        arm = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic        rd_ready = 1'b0;

    logic        d_valid [2];
    logic [31:0] d_pc [2];
    logic [31:0] d_instr [2];
    logic [4:0]  d_rd [2];
    logic [31:0] d_wdata [2];
    logic [15:0] d_stamp [2];
    logic [2:0]  d_count [2];
    logic        d_ovf [2];
    logic        d_halt [2];
    logic [1:0]  d_state [2];

    int n_checks = 0;
    int n_fail = 0;

    ent_q_t      mq0, mq1;
    logic [1:0]  mst [2];
    logic        movf [2];
    logic [15:0] m_stamp = '0;

    always #5 CLK = ~CLK;

    exec_trace_buffer #(.XLEN(32), .DEPTH(4), .CW(16), .WRAP(1)) u_wrap (
        .CLK(CLK), .RST(RST), .commit(commit), .pc(pc), .instr(instr), .rd(rd),
        .wdata(wdata), .arm(arm), .bp_en(bp_en), .bp_addr(bp_addr), .rd_ready(rd_ready),
        .rd_valid(d_valid[0]), .rd_pc(d_pc[0]), .rd_instr(d_instr[0]), .rd_rd(d_rd[0]),
        .rd_wdata(d_wdata[0]), .rd_stamp(d_stamp[0]), .count(d_count[0]),
        .overflow(d_ovf[0]), .halt(d_halt[0]), .state(d_state[0])
    );

    exec_trace_buffer #(.XLEN(32), .DEPTH(4), .CW(16), .WRAP(0)) u_drop (
        .CLK(CLK), .RST(RST), .commit(commit), .pc(pc), .instr(instr), .rd(rd),
        .wdata(wdata), .arm(arm), .bp_en(bp_en), .bp_addr(bp_addr), .rd_ready(rd_ready),
        .rd_valid(d_valid[1]), .rd_pc(d_pc[1]), .rd_instr(d_instr[1]), .rd_rd(d_rd[1]),
        .rd_wdata(d_wdata[1]), .rd_stamp(d_stamp[1]), .count(d_count[1]),
        .overflow(d_ovf[1]), .halt(d_halt[1]), .state(d_state[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model for one instance; evaluated with the inputs present before the edge.
    task automatic model(inout ent_q_t q, inout logic [1:0] st, inout logic ovf,
                         input bit wrap, input ent_t e);
        bit do_pop, do_push, is_full;
        if (!RST) begin
            q.delete();
            st  = 2'b00;
            ovf = 1'b0;
        end else if (arm) begin
            q.delete();
            st  = 2'b01;
            ovf = 1'b0;
        end else begin
            do_pop  = (q.size() != 0) && rd_ready;
            do_push = commit && (st == 2'b01);
            is_full = (q.size() == 4);
            if (do_push && bp_en && (pc == bp_addr)) st = 2'b10;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (do_pop || !is_full) begin
                    q.push_back(e);
                end else begin
                    ovf = 1'b1;
                    if (wrap) begin
                        void'(q.pop_front());
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input ent_q_t q, input logic [1:0] st, input logic ovf);
        ent_t  h;
        string p;
        h = '0;
        if (q.size() != 0) h = q[0];
        p = (i == 0) ? "wrap" : "drop";
        check_eq({p, ".count"}, 64'(d_count[i]), 64'(q.size()));
        check_eq({p, ".valid"}, 64'(d_valid[i]), 64'(q.size() != 0));
        check_eq({p, ".pc"}, 64'(d_pc[i]), 64'(h.pc));
        check_eq({p, ".instr"}, 64'(d_instr[i]), 64'(h.instr));
        check_eq({p, ".rd"}, 64'(d_rd[i]), 64'(h.rd));
        check_eq({p, ".wdata"}, 64'(d_wdata[i]), 64'(h.wdata));
        check_eq({p, ".stamp"}, 64'(d_stamp[i]), 64'(h.stamp));
        check_eq({p, ".overflow"}, 64'(d_ovf[i]), 64'(ovf));
        check_eq({p, ".halt"}, 64'(d_halt[i]), 64'(st == 2'b10));
        check_eq({p, ".state"}, 64'(d_state[i]), 64'(st));
    endtask

    task automatic step(input logic rst_v, input logic arm_v, input logic commit_v,
                        input logic [31:0] pc_v, input logic bp_en_v, input logic [31:0] bp_v,
                        input logic ready_v);
        ent_t e;
        RST      = rst_v;
        arm      = arm_v;
        commit   = commit_v;
        pc       = pc_v;
        bp_en    = bp_en_v;
        bp_addr  = bp_v;
        rd_ready = ready_v;
        instr    = $urandom;
        rd       = 5'($urandom_range(0, 31));
        wdata    = $urandom;
        e        = '{pc: pc_v, instr: instr, rd: rd, wdata: wdata, stamp: m_stamp};
        model(mq0, mst[0], movf[0], 1'b1, e);
        model(mq1, mst[1], movf[1], 1'b0, e);
        m_stamp = rst_v ? m_stamp + 16'd1 : 16'd0;
        @(posedge CLK);
        #1;
        check_dut(0, mq0, mst[0], movf[0]);
        check_dut(1, mq1, mst[1], movf[1]);
    endtask

    task automatic idle(input int n, input logic ready_v);
        for (int k = 0; k < n; k++) step(1, 0, 0, 32'h0, 0, 32'h0, ready_v);
    endtask

    initial begin
        mst[0] = 2'b00; mst[1] = 2'b00;
        movf[0] = 1'b0; movf[1] = 1'b0;

        // Reset, then commits in IDLE are ignored.
        step(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h40, 0, 32'h0, 1);
        step(1, 0, 1, 32'h44, 0, 32'h0, 0);

        // Three commits held, then popped in order.
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 32'(4 * k), 0, 32'h0, 0);
        idle(4, 1);

        // Six commits into a 4-deep buffer, then drain.
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 6; k++) step(1, 0, 1, 32'(4 * k), 0, 32'h0, 0);
        idle(5, 1);

        // Full buffer with simultaneous commit and pop, then arm together with commit.
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 1, 32'(4 * k), 0, 32'h0, 0);
        step(1, 0, 1, 32'h20, 0, 32'h0, 1);
        step(1, 0, 1, 32'h24, 0, 32'h0, 1);
        step(1, 1, 1, 32'h28, 0, 32'h0, 1);
        idle(1, 1);

        // Breakpoint at 0x10 freezes capture; pops still work while frozen.
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 1, 32'h0C, 1, 32'h10, 0);
        step(1, 0, 1, 32'h10, 1, 32'h10, 0);
        step(1, 0, 1, 32'h14, 1, 32'h10, 0);
        step(1, 0, 1, 32'h10, 1, 32'h10, 0);
        idle(1, 1);
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);

        // Breakpoint commit arriving when full: dropped by WRAP=0 but still freezes.
        for (int k = 0; k < 4; k++) step(1, 0, 1, 32'(4 * k), 1, 32'h10, 0);
        step(1, 0, 1, 32'h10, 1, 32'h10, 0);
        idle(5, 1);

        // Reset mid-capture with three entries, then capture again from stamp 0.
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 32'(4 * k), 0, 32'h0, 0);
        step(0, 0, 1, 32'h30, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 1, 32'h34, 0, 32'h0, 0);
        idle(2, 1);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 6), 32'(4 * $urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), 32'(4 * $urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_trace_buffer.md
EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of the PC and writeback data.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the trace entries held; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter CW, default 16, giving the cycle-stamp width.
REQ-004 The block SHALL have parameter WRAP, default 1: 1 = overwrite oldest when full, 0 = drop newest when full.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port commit, input, 1 bit: the core retired one instruction this cycle.
REQ-008 The block SHALL have port pc, input, XLEN bits: PC of the retiring instruction.
REQ-009 The block SHALL have port instr, input, 32 bits: the retiring instruction word.
REQ-010 The block SHALL have port rd, input, 5 bits: destination register (0 = none).
REQ-011 The block SHALL have port wdata, input, XLEN bits: register writeback data.
REQ-012 The block SHALL have port arm, input, 1 bit: a pulse that clears the buffer and starts capture.
REQ-013 The block SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-014 The block SHALL have port bp_addr, input, XLEN bits: breakpoint PC.
REQ-015 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts the head entry.
REQ-016 The block SHALL have port rd_valid, output, 1 bit: the head entry is present.
REQ-017 The block SHALL have outputs rd_pc (XLEN), rd_instr (32), rd_rd (5), rd_wdata (XLEN) and rd_stamp (CW): the head entry fields.
REQ-018 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: entries held.
REQ-019 The block SHALL have port overflow, output, 1 bit: sticky flag, an entry was lost or overwritten.
REQ-020 The block SHALL have port halt, output, 1 bit: a breakpoint has been hit and is requesting a core stall.
REQ-021 The block SHALL have port state, output, 2 bits: IDLE=00, CAPTURE=01, FROZEN=10.

Function
REQ-022 The stamp counter SHALL be CW bits wide, free-running, increment every cycle, wrap to 0 after all-ones, and read 0 in the first cycle after reset.
REQ-023 Each entry SHALL store {pc, instr, rd, wdata, stamp}, with stamp equal to the counter value in the commit cycle.
REQ-024 In IDLE, commits SHALL be ignored; arm=1 SHALL empty the buffer, clear overflow and move to CAPTURE.
REQ-025 In CAPTURE, each cycle with commit=1 SHALL write one entry at the tail.
REQ-026 In CAPTURE, a commit with bp_en=1 and pc==bp_addr SHALL write its entry, move to FROZEN, and set halt=1 on the next cycle.
REQ-027 In FROZEN, commits SHALL be ignored and halt SHALL hold at 1; only arm leaves FROZEN, going to CAPTURE with the buffer emptied, overflow cleared and halt=0 on the next cycle.
REQ-028 Arm while in CAPTURE SHALL empty the buffer and clear overflow, remaining in CAPTURE.
REQ-029 Arm together with commit SHALL perform the clear; that commit SHALL NOT be recorded.
REQ-030 Arm together with a pop SHALL perform the clear; the pop has no additional effect.
REQ-031 rd_* SHALL be show-ahead, presenting the oldest entry whenever rd_valid=1.
REQ-032 rd_valid SHALL equal (count!=0); a pop occurs when rd_valid && rd_ready, in any state.
REQ-033 An entry written at edge N SHALL be visible on rd_* and count after edge N, i.e. 1-cycle latency.
REQ-034 Push without pop SHALL give count+1; pop without push SHALL give count-1; push with pop SHALL leave count unchanged and SHALL NOT set overflow, including when full.
REQ-035 With WRAP=1, a push when full and not popping SHALL overwrite the oldest entry, advance the head, keep count=DEPTH and set overflow.
REQ-036 With WRAP=0, a push when full and not popping SHALL discard the new entry, leave the buffer unchanged and set overflow.
REQ-037 A breakpoint commit that cannot be stored (WRAP=0, full) SHALL still cause FROZEN and halt.
REQ-038 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-039 rd_rd=0 entries SHALL be stored and read out like any other entry.

Reset
REQ-040 With RST=0 at a rising edge: state=IDLE, count=0, rd_valid=0, overflow=0, halt=0, pointers=0, stamp counter=0.
REQ-041 While in reset, rd_pc, rd_instr, rd_rd, rd_wdata and rd_stamp SHALL read 0.
REQ-042 Buffer memory SHALL need no reset; its contents are never visible while count=0.
REQ-043 Reset asserted mid-capture or in FROZEN SHALL discard all entries and release halt the next cycle.

Verification
REQ-044 DEPTH=4: arm, then commits pc=0x00,0x04,0x08 with rd_ready=0 -> count=3, rd_pc=0x00; three pops -> rd_pc 0x00,0x04,0x08, then rd_valid=0.
REQ-045 DEPTH=4, WRAP=1: 6 commits pc=0x00..0x14 step 4, no pops -> count=4, overflow=1, readout order 0x08,0x0C,0x10,0x14.
REQ-046 DEPTH=4, WRAP=0: same stimulus as REQ-045 -> readout 0x00..0x0C, overflow=1.
REQ-047 bp_en=1, bp_addr=0x10, commits 0x0C,0x10,0x14 -> entries 0x0C,0x10 only; state=10; halt=1 the cycle after the 0x10 commit; arm -> state=01, count=0, halt=0.
REQ-048 Full buffer, commit and pop in the same cycle -> count stays 4, overflow stays 0; arm with commit -> count=0.
REQ-049 RST=0 for one cycle during CAPTURE with count=3 -> count=0, state=00, stamp=0 on the next cycle.
